// File: rtl/fv_ooo_buffer_if.sv
// Push/pop handshake bundle for fv_ooo_buffer.
// The master side offers pushes and steers pops; the slave side is the buffer.
interface fv_ooo_buffer_if #(
  parameter int DWIDTH = 4,
  parameter int DEPTH  = 4
);
  logic                         push_valid;
  logic [DWIDTH-1:0]            push_data;
  logic                         push_ready;
  logic [$clog2(DEPTH)-1:0]     pop_sel;
  logic                         pop_ready;
  logic                         pop_valid;
  logic [DWIDTH-1:0]            pop_data;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output push_valid, push_data, pop_sel, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );

  modport slave (
    input  push_valid, push_data, pop_sel, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );
endinterface

// File: rtl/fv_ooo_buffer.sv
// Small out-of-order buffer: pushes fill the lowest free slot, pops follow an
// external select, and a per-slot age counter forces out any item that has
// waited MAX_AGE cycles so every item is eventually delivered.
module fv_ooo_buffer #(
  parameter int DWIDTH  = 4,
  parameter int DEPTH   = 4,
  parameter int MAX_AGE = 7
) (
  input  logic               clk,
  input  logic               rstn,
  fv_ooo_buffer_if.slave     bus
);
  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(MAX_AGE + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_AGE);

  logic [DEPTH-1:0]  valid;
  logic [DWIDTH-1:0] data [DEPTH];
  logic [AGE_W-1:0]  age  [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [SEL_W-1:0]  free_idx;
  logic [SEL_W-1:0]  first_idx;
  logic [SEL_W-1:0]  forced_idx;
  logic [SEL_W-1:0]  sel_idx;
  logic              forced_hit;
  logic              push_fire;
  logic              pop_fire;

  // Priority searches over registered slot state: lowest free slot, lowest
  // valid slot, and lowest valid slot that has reached the age limit.
  // NOTE: every combinational output gets a default before the loops so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    free_idx   = '0;
    first_idx  = '0;
    forced_idx = '0;
    forced_hit = 1'b0;
    // Walking downwards leaves the lowest matching index as the final value.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = SEL_W'(i);
      if (valid[i]) first_idx = SEL_W'(i);
      if (valid[i] && (age[i] == AGE_MAX)) begin
        forced_idx = SEL_W'(i);
        forced_hit = 1'b1;
      end
    end
  end

  // Pop slot choice: a starved slot beats the requested one, which beats the
  // lowest valid slot.
  always_comb begin
    if (forced_hit)              sel_idx = forced_idx;
    else if (valid[bus.pop_sel]) sel_idx = bus.pop_sel;
    else                         sel_idx = first_idx;
  end

  // Handshake outputs; push_ready depends only on registered occupancy.
  always_comb begin
    bus.push_ready = ~(&valid);
    bus.pop_valid  = |valid;
    bus.pop_data   = (|valid) ? data[sel_idx] : '0;
    bus.count      = count_q;
    push_fire      = bus.push_valid & ~(&valid);
    pop_fire       = (|valid) & bus.pop_ready;
  end

  // Slot state: pop clears, push fills, everything else still waiting ages.
  // NOTE: state registers use non-blocking assignments so every slot sees the
  // same pre-edge values regardless of statement order.
  // NOTE: the data array is cleared on reset as well, because an empty buffer
  // must present zero and no stale payload may survive a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
        age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_fire && (sel_idx == SEL_W'(i))) begin
          valid[i] <= 1'b0;
          age[i]   <= '0;
        end else if (push_fire && (free_idx == SEL_W'(i))) begin
          // The free slot comes from pre-pop state, so it never equals the
          // slot being popped in the same cycle.
          valid[i] <= 1'b1;
          data[i]  <= bus.push_data;
          age[i]   <= '0;
        end else if (valid[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (push_fire && !pop_fire) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop_fire && !push_fire) begin
      count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: doc/fv_ooo_buffer.md
# fv_ooo_buffer

- Small out-of-order data buffer; the design under test whose push/pop streams feed the team's formal data-integrity scoreboards.
- Accepts items into free slots. Releases them in an order steered by an external, formally unconstrained select input.
- An age-based starvation guard bounds how long any item can wait, so eventual-delivery checks are provable.
- Its push and pop handshakes connect one-to-one to the scoreboard's push and pop observation ports.

## Interface
- DWIDTH, 4, payload width in bits
- DEPTH, 4, number of slots (power of two, >= 2)
- MAX_AGE, 7, wait-cycle threshold at which a slot is forced out (>= 1)
- clk  input  1  single clock; all state on rising edge
- rstn  input  1  asynchronous active-low reset
- push_valid  input  1  upstream offers push_data
- push_data  input  DWIDTH  payload
- push_ready  output  1  buffer can accept; transfer when push_valid && push_ready
- pop_sel  input  $clog2(DEPTH)  preferred slot to release this cycle
- pop_ready  input  1  downstream accepts; transfer when pop_valid && pop_ready
- pop_valid  output  1  an item is presented
- pop_data  output  DWIDTH  presented payload
- count  output  $clog2(DEPTH+1)  number of occupied slots

## Operation
- Per-slot state:
  - valid bit
  - DWIDTH data register
  - age counter of width $clog2(MAX_AGE+1), saturating at MAX_AGE
- Push:
  - push_ready = !(&valid). It is computed from registered state only, so a full buffer stays not-ready even in a popping cycle.
  - An accepted push writes the lowest-index free slot, sets its valid bit and clears its age to 0.
- Pop selection, combinational from registered state and pop_sel, first match wins:
  1. The lowest-index valid slot with age == MAX_AGE (forced).
  2. pop_sel, if valid[pop_sel].
  3. The lowest-index valid slot.
- pop_valid = |valid. pop_data = data of the selected slot, or 0 when pop_valid = 0.
- An accepted pop clears the selected slot's valid bit and age. The data register is left unchanged.
- Aging: every valid slot not popped this cycle increments its age, saturating at MAX_AGE. Aging continues while pop_ready = 0.
- Simultaneous push and pop in one cycle:
  - The free-slot search uses pre-pop state, so the popped slot is not reused that cycle.
  - count is unchanged.
- count increments on push only, decrements on pop only.
- No data transformation, duplication or drop: every accepted push_data is presented exactly once.
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - All valid, age and data registers cleared.
  - push_ready=1, pop_valid=0, pop_data=0, count=0.
  - Reset during an operation discards all contents immediately. No pop is presented until a new push completes.

## Timing
- Push-to-pop latency is at least 1 cycle. An item accepted in cycle N is visible on pop_valid/pop_data from cycle N+1; there is no bypass.
- Starvation bound, assuming pop_ready is asserted in every cycle:
  - An item waits at most MAX_AGE + DEPTH - 1 cycles after becoming visible.
  - Forced slots are served lowest index first, one per cycle.
- pop_data/pop_valid may change combinationally with pop_sel within a cycle. They are stable only with respect to the registered state.
- push_ready has no combinational path from any input.
- count reflects completed transfers one cycle after the handshake.

## Test plan
- Reset, then push 0x3 in cycle 1 -> cycle 2: pop_valid=1, pop_data=0x3, count=1; pop with pop_ready=1 -> cycle 3: pop_valid=0, count=0.
- Fill 4 slots with 0x1,0x2,0x3,0x4; push_valid held with 0x5 -> push_ready=0, count=4. Pop with pop_sel=2 -> 0x3 released; next cycle push_ready=1 and 0x5 lands in slot 2.
- Slots hold 0xA (slot0), 0xB (slot1); pop_sel=3 (empty) -> fallback presents 0xA.
- Single item in slot 1, pop_ready=0 for 7 cycles, with pop_sel=0 -> slot 1 presented throughout. Push 0xC into slot 0 and keep pop_sel=0 -> after slot 1 age reaches 7, the pop presents slot 1 over pop_sel.
- Push and pop in the same cycle with count=2 -> count stays 2, popped slot not reused.
- Assert rstn low mid-stream with count=3 -> immediately pop_valid=0, count=0, push_ready=1; no stale data presented after release.
